// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX->MEM pipeline register with stall, flush, valid and forward-qualify
module ex_mem_pipe_reg #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RES_SRC_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallM,
    input  logic                  FlushM,
    input  logic                  ValidE,
    input  logic                  RegWriteE,
    input  logic [RES_SRC_W-1:0]  ResultSrcE,
    input  logic                  MemWriteE,
    input  logic [WIDTH-1:0]      ALUResultE,
    input  logic [WIDTH-1:0]      WriteDataE,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [WIDTH-1:0]      PCPlus4E,
    output logic                  ValidM,
    output logic                  RegWriteM,
    output logic [RES_SRC_W-1:0]  ResultSrcM,
    output logic                  MemWriteM,
    output logic [WIDTH-1:0]      ALUResultM,
    output logic [WIDTH-1:0]      WriteDataM,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic [WIDTH-1:0]      PCPlus4M,
    output logic                  FwdValidM
);

    // Architectural enables are qualified by ValidE so a bubble can never write state.
    logic reg_write_q;
    logic mem_write_q;
    logic rd_nonzero;

    assign reg_write_q = RegWriteE & ValidE;
    assign mem_write_q = MemWriteE & ValidE;
    assign rd_nonzero  = (RdE != '0);

    always_ff @(posedge clk) begin
        if (rst || FlushM) begin
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            ResultSrcM <= '0;
            MemWriteM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RdM        <= '0;
            PCPlus4M   <= '0;
            FwdValidM  <= 1'b0;
        end else if (!StallM) begin
            ValidM     <= ValidE;
            RegWriteM  <= reg_write_q;
            ResultSrcM <= ResultSrcE;
            MemWriteM  <= mem_write_q;
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            RdM        <= RdE;
            PCPlus4M   <= PCPlus4E;
            FwdValidM  <= reg_write_q & rd_nonzero;
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb/tb_ex_mem_pipe_reg.sv - scoreboard testbench for ex_mem_pipe_reg
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, StallM, FlushM, ValidE, RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic        ValidM, RegWriteM, MemWriteM, FwdValidM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    ex_mem_pipe_reg #(.WIDTH(32), .REG_ADDR_W(5), .RES_SRC_W(2)) dut (
        .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RdE(RdE), .PCPlus4E(PCPlus4E),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M), .FwdValidM(FwdValidM)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        fwd;
    } m_t;

    typedef struct {
        logic        r, st, fl, ve, rwe, mwe;
        logic [1:0]  rse;
        logic [31:0] alu, wd, pc;
        logic [4:0]  rd;
    } in_t;

    m_t  model;
    m_t  sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic in_t rand_in();
        in_t i;
        i.r = 1'b0; i.st = 1'b0; i.fl = 1'b0;
        i.ve  = 1'($urandom);
        i.rwe = 1'($urandom);
        i.mwe = 1'($urandom);
        i.rse = 2'($urandom);
        i.alu = $urandom;
        i.wd  = $urandom;
        i.pc  = $urandom;
        i.rd  = 5'($urandom);
        return i;
    endfunction

    task automatic compare_out();
        m_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val("ValidM",     {31'd0, ValidM},    {31'd0, e.v});
            check_val("RegWriteM",  {31'd0, RegWriteM}, {31'd0, e.rw});
            check_val("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, e.rs});
            check_val("MemWriteM",  {31'd0, MemWriteM}, {31'd0, e.mw});
            check_val("ALUResultM", ALUResultM, e.alu);
            check_val("WriteDataM", WriteDataM, e.wd);
            check_val("RdM",        {27'd0, RdM},       {27'd0, e.rd});
            check_val("PCPlus4M",   PCPlus4M, e.pc);
            check_val("FwdValidM",  {31'd0, FwdValidM}, {31'd0, e.fwd});
        end
    endtask

    // Drive one cycle of E-stage inputs, predict the M-stage result, then check it after the edge.
    task automatic drive(input in_t i);
        m_t n;
        @(negedge clk);
        rst = i.r; StallM = i.st; FlushM = i.fl;
        ValidE = i.ve; RegWriteE = i.rwe; MemWriteE = i.mwe; ResultSrcE = i.rse;
        ALUResultE = i.alu; WriteDataE = i.wd; RdE = i.rd; PCPlus4E = i.pc;
        if (i.r || i.fl) begin
            n = '0;
        end else if (i.st) begin
            n = model;
        end else begin
            n.v   = i.ve;
            n.rw  = i.ve ? i.rwe : 1'b0;
            n.mw  = i.ve ? i.mwe : 1'b0;
            n.rs  = i.rse;
            n.alu = i.alu;
            n.wd  = i.wd;
            n.rd  = i.rd;
            n.pc  = i.pc;
            n.fwd = i.ve && i.rwe && (i.rd != 5'd0);
        end
        model = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        in_t i;
        model = '0;
        rst = 1'b1; StallM = 1'b0; FlushM = 1'b0; ValidE = 1'b0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = '0;
        ALUResultE = '0; WriteDataE = '0; RdE = '0; PCPlus4E = '0;

        // 1: reset with random inputs, then first capture
        for (int k = 0; k < 2; k++) begin
            i = rand_in(); i.r = 1'b1; i.ve = 1'b1; drive(i);
        end
        check_val("rst_alu", ALUResultM, 32'd0);
        check_val("rst_valid", {31'd0, ValidM}, 32'd0);
        i = rand_in(); i.ve = 1'b1; i.alu = 32'hDEADBEEF; i.rd = 5'd5; drive(i);
        check_val("t1_alu", ALUResultM, 32'hDEADBEEF);
        check_val("t1_rd", {27'd0, RdM}, 32'd5);

        // 2: back-to-back stream, then a write to x0
        for (int k = 1; k <= 3; k++) begin
            i = rand_in(); i.ve = 1'b1; i.rwe = 1'b1; i.rd = 5'(k); drive(i);
            check_val("t2_rd", {27'd0, RdM}, 32'(k));
            check_val("t2_fwd", {31'd0, FwdValidM}, 32'd1);
        end
        i = rand_in(); i.ve = 1'b1; i.rwe = 1'b1; i.rd = 5'd0; drive(i);
        check_val("t2_x0_fwd", {31'd0, FwdValidM}, 32'd0);
        check_val("t2_x0_rw", {31'd0, RegWriteM}, 32'd1);

        // 3: stall holds for three cycles
        i = rand_in(); i.ve = 1'b1; i.rd = 5'd7; drive(i);
        for (int k = 0; k < 3; k++) begin
            i = rand_in(); i.st = 1'b1; i.rd = 5'd9; drive(i);
            check_val("t3_hold_rd", {27'd0, RdM}, 32'd7);
        end
        i = rand_in(); i.rd = 5'd9; drive(i);
        check_val("t3_release_rd", {27'd0, RdM}, 32'd9);

        // 4: flush beats stall
        i = rand_in(); i.ve = 1'b1; i.mwe = 1'b1; drive(i);
        check_val("t4_mw_pre", {31'd0, MemWriteM}, 32'd1);
        i = rand_in(); i.fl = 1'b1; i.st = 1'b1; drive(i);
        check_val("t4_valid", {31'd0, ValidM}, 32'd0);
        check_val("t4_mw", {31'd0, MemWriteM}, 32'd0);
        check_val("t4_pc", PCPlus4M, 32'd0);

        // 5: invalid instruction cannot write
        i = rand_in(); i.ve = 1'b0; i.rwe = 1'b1; i.mwe = 1'b1; i.rd = 5'd3;
        i.alu = 32'h1234_5678; drive(i);
        check_val("t5_rw", {31'd0, RegWriteM}, 32'd0);
        check_val("t5_mw", {31'd0, MemWriteM}, 32'd0);
        check_val("t5_fwd", {31'd0, FwdValidM}, 32'd0);
        check_val("t5_alu", ALUResultM, 32'h1234_5678);

        // 6: reset wins over stall and over flush
        i = rand_in(); i.ve = 1'b1; i.rwe = 1'b1; i.rd = 5'd4; i.alu = 32'hA5A5_0001; drive(i);
        i = rand_in(); i.r = 1'b1; i.st = 1'b1; drive(i);
        check_val("t6_alu", ALUResultM, 32'd0);
        check_val("t6_rd", {27'd0, RdM}, 32'd0);
        i = rand_in(); i.r = 1'b1; i.fl = 1'b1; drive(i);
        i = rand_in(); i.ve = 1'b1; i.pc = 32'h0000_0104; drive(i);
        check_val("t6_first_pc", PCPlus4M, 32'h0000_0104);

        // Random mix of capture, stall, flush and reset
        for (int k = 0; k < 300; k++) begin
            i = rand_in();
            i.st = ($urandom_range(0, 3) == 0);
            i.fl = ($urandom_range(0, 7) == 0);
            i.r  = ($urandom_range(0, 19) == 0);
            drive(i);
        end

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
